// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO control and its read-side drain controller.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } drain_state_t;

    localparam int WIDTH     = 4;
    localparam int CNT_WIDTH = 8;

endpackage

// File: rtl/fifo_drain_if.sv
// FIFO read port plus downstream valid/ready sink, bundled for the drain controller.
interface fifo_drain_if
    import fifo_pkg::*;
#(
    parameter int width = WIDTH
);
    logic             read;
    logic             empty;
    logic [width-1:0] front_data;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] out_data;

    modport master (
        output read,
        input  empty,
        input  front_data,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport slave (
        input  read,
        output empty,
        output front_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );
endinterface

// File: rtl/fifo_drain_buf.sv
// Two-entry ordered output buffer; head is always the oldest word.
// Push and pop may coincide; the head only changes on a pop or a push into an empty buffer.
module fifo_drain_buf #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [width-1:0] i_push_data,
    input  logic             i_pop,
    output logic [width-1:0] o_head,
    output logic [1:0]       o_occ
);

    logic [width-1:0] r_head;
    logic [width-1:0] r_tail;
    logic [1:0]       r_occ;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop & (r_occ != 2'd0);
    assign w_push = i_push & ((r_occ != 2'd2) | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    // Surviving entry (if any) moves to head, new word lands behind it.
                    if (r_occ == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end else begin
                        r_head <= i_push_data;
                    end
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= i_push_data;
                    end else begin
                        r_tail <= i_push_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_head = r_head;
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_drain.sv
// Issues read pulses to the FIFO and streams returned words in order to a valid/ready sink.
// Word appears two cycles after its read; credits cap outstanding words at two, so the sink may stall freely.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int width     = WIDTH,
    parameter int cnt_width = CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_enable,
    output logic                 o_busy,
    output logic [cnt_width-1:0] o_words_out,
    fifo_drain_if.master         bus
);

    drain_state_t         r_state;
    logic                 r_inflight;
    logic [cnt_width-1:0] r_words_out;

    logic [1:0]       w_occ;
    logic [width-1:0] w_head;
    logic             w_pop;
    logic             w_read;
    logic [2:0]       w_credit;
    logic             w_occ_next_zero;

    // Occupancy after this edge: current entries plus the capture, minus the pop.
    assign w_credit        = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_occ_next_zero = (w_credit == 3'd0);

    assign w_pop  = bus.out_valid & bus.out_ready;
    assign w_read = i_enable & ~bus.empty & (r_state != DRAIN) & (w_credit < 3'd2);

    fifo_drain_buf #(
        .width (width)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_push      (r_inflight),
        .i_push_data (bus.front_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_inflight  <= 1'b0;
            r_words_out <= '0;
        end else begin
            r_inflight <= w_read;
            if (w_pop) begin
                r_words_out <= r_words_out + cnt_width'(1);
            end
            case (r_state)
                IDLE: begin
                    if (i_enable & ~bus.empty) begin
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!i_enable) begin
                        r_state <= ((w_occ != 2'd0) | r_inflight) ? DRAIN : IDLE;
                    end else if (bus.empty & (w_occ == 2'd0) & ~r_inflight & ~w_read) begin
                        r_state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (i_enable) begin
                        r_state <= ACTIVE;
                    end else if (w_occ_next_zero) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.read      = w_read;
    assign bus.out_valid = (w_occ != 2'd0);
    assign bus.out_data  = w_head;
    assign o_busy        = (r_state != IDLE);
    assign o_words_out   = r_words_out;

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: behavioural FIFO on the read port, scoreboard on the sink side.
module tb_fifo_drain;
    import fifo_pkg::*;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       busy;
    logic [7:0] words_out;

    fifo_drain_if #(.width(4)) bus ();

    fifo_drain #(
        .width     (4),
        .cnt_width (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_enable    (enable),
        .o_busy      (busy),
        .o_words_out (words_out),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: storage and write pointer owned by the stimulus, read pointer here.
    logic [3:0] fmem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign bus.empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (reset) begin
            rd_ptr         <= wr_ptr;
            bus.front_data <= 4'h0;
        end else if (bus.read) begin
            bus.front_data <= fmem[rd_ptr];
            rd_ptr         <= rd_ptr + 1;
        end
    end

    int         vectors = 0;
    int         misc    = 0;
    int         cyc     = 0;
    logic [3:0] sb [$];
    int         rd_q [$];
    int         pop_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misc++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] w);
        fmem[wr_ptr] = w;
        wr_ptr       = wr_ptr + 1;
        sb.push_back(w);
    endtask

    task automatic cycle();
        logic [3:0] exp;
        @(negedge clk);
        if (bus.read === 1'b1) rd_q.push_back(cyc);
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            pop_q.push_back(cyc);
            if (sb.size() == 0) begin
                check("extra_word", 32'(sb.size()), 32'd1);
            end else begin
                exp = sb.pop_front();
                check("data", 32'(bus.out_data), 32'(exp));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int max_cycles);
        int k = 0;
        while (sb.size() > 0 && k < max_cycles) begin
            cycle();
            k++;
        end
        check("drain_done", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_idle(input int max_cycles);
        int k = 0;
        while (busy !== 1'b0 && k < max_cycles) begin
            cycle();
            k++;
        end
        check("idle", 32'(busy), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        bus.out_ready = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_words", 32'(words_out), 32'd0);
        check("rst_read", 32'(bus.read), 32'd0);

        // Three preloaded words, sink always ready.
        load(4'hA); load(4'hB); load(4'hC);
        rd_q.delete(); pop_q.delete();
        enable        = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        check("t1_reads", 32'(rd_q.size()), 32'd3);
        check("t1_pops", 32'(pop_q.size()), 32'd3);
        if (rd_q.size() == 3 && pop_q.size() == 3) begin
            check("t1_read_span", 32'(rd_q[2] - rd_q[0]), 32'd2);
            check("t1_latency", 32'(pop_q[0] - rd_q[0]), 32'd2);
            check("t1_pop_span", 32'(pop_q[2] - pop_q[0]), 32'd2);
        end
        check("t1_words", 32'(words_out), 32'd3);
        check("t1_busy", 32'(busy), 32'd0);

        // Four words, sink stalled: only two reads, head held.
        bus.out_ready = 1'b0;
        rd_q.delete(); pop_q.delete();
        load(4'h1); load(4'h2); load(4'h3); load(4'h4);
        for (int i = 0; i < 3; i++) cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t2_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t2_hold_data", 32'(bus.out_data), 32'h1);
        end
        check("t2_reads", 32'(rd_q.size()), 32'd2);
        bus.out_ready = 1'b1;
        drain(20);
        check("t2_pops", 32'(pop_q.size()), 32'd4);
        if (pop_q.size() == 4) check("t2_no_gap", 32'(pop_q[3] - pop_q[0]), 32'd3);
        wait_idle(10);

        // Enable dropped right after a read: in-flight word still delivered.
        rd_q.delete(); pop_q.delete();
        load(4'h5); load(4'h6);
        cycle();
        enable = 1'b0;
        cycle();
        check("t3_drain_state", 32'(dut.r_state), 32'(DRAIN));
        check("t3_drain_valid", 32'(bus.out_valid), 32'd1);
        wait_idle(10);
        check("t3_reads", 32'(rd_q.size()), 32'd1);
        check("t3_pops", 32'(pop_q.size()), 32'd1);

        // The remaining single word; empty rises right after its read.
        rd_q.delete(); pop_q.delete();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        check("t4_reads", 32'(rd_q.size()), 32'd1);
        check("t4_pops", 32'(pop_q.size()), 32'd1);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);

        // Reset with the buffer full and a word left in the FIFO.
        bus.out_ready = 1'b0;
        load(4'h7); load(4'h8); load(4'h9);
        for (int i = 0; i < 4; i++) cycle();
        check("t5_full_valid", 32'(bus.out_valid), 32'd1);
        check("t5_full_head", 32'(bus.out_data), 32'h7);
        check("t5_words_pre", 32'(words_out), 32'd9);
        reset = 1'b1;
        sb.delete();
        cycle();
        check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_words", 32'(words_out), 32'd0);
        check("t5_rst_read", 32'(bus.read), 32'd0);
        reset = 1'b0;
        cycle();

        // Long stream across the counter wrap.
        pop_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 260; i++) load(4'(i * 7 + 3));
        drain(600);
        check("t6_pops", 32'(pop_q.size()), 32'd260);
        check("t6_words_wrap", 32'(words_out), 32'd4);
        wait_idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
